piso_tx_scheduler: RTL
======================

# piso_tx_scheduler

Round-robin transmit scheduler that shares one parallel-to-serial output line among `NREQ` byte producers. It grants one requester at a time and latches that requester's byte. It then frames and shifts the byte onto `tx` MSB-first at a fixed bit period. Sits between the byte-producing blocks and the single serial pin, and replaces ad-hoc `charge` sequencing of the serializer.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `CLKS_PER_BIT`, 16, clock cycles per serial bit (>=2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  NREQ  per-requester transmit request, level, held until `ack`
- `data`  in  8*NREQ  byte of requester k on bits [8k+7:8k]
- `ack`  out  NREQ  one-cycle pulse: byte of requester k latched
- `grant_id`  out  clog2(NREQ)  index of requester owning the current frame
- `busy`  out  1  high while a frame is on the line
- `done`  out  1  one-cycle pulse at the end of each stop bit
- `tx`  out  1  serial line, idle high

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Arbitration is round-robin. The search starts at `last+1` mod NREQ, where `last` is the most recently granted index. `last` resets to NREQ-1, so requester 0 wins first.
- Grant in IDLE, or on the last cycle of STOP:
  - latch the winner's byte into the shift register;
  - set `grant_id`;
  - pulse `ack[winner]`;
  - enter START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, bit 7 first, each held CLKS_PER_BIT cycles. A 3-bit bit index counts 7 down to 0, then the block leaves DATA.
- PARITY: one bit period (see Configuration).
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `done` pulses on the last cycle of STOP.
- End of STOP:
  - if any `req` is high, the next grant happens on the same edge (back-to-back, no idle gap);
  - otherwise the block returns to IDLE.
- Bit-period counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and clears on grant.
- `req` deasserted after `ack` has no effect on the frame in flight. `req` deasserted before `ack` means no grant.
- `data` is sampled only on the grant edge. Later changes do not affect the frame in flight.
- Reset at any time, including mid-frame:
  - `tx`=1, `ack`=0, `busy`=0, `done`=0, `grant_id`=0;
  - state IDLE, `last`=NREQ-1;
  - the frame is dropped, with no `done`.

## Timing
- All outputs are registered.
- Grant edge T (`req` high, state IDLE): in the cycle after T, `ack`=1, `busy`=1 and `tx`=0.
- Frame length: F = 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- `done` is high in the last cycle of the frame.
- Single frame: `busy` falls on the edge after `done`.
- Back-to-back frames:
  - `busy` stays high;
  - the next `ack` coincides with the first START cycle of the next frame;
  - `tx` goes 1→0 directly with no extra idle cycle.
- Latency from `req` rise (state IDLE) to the first START cycle on `tx`: 1 cycle.
- `ack` is one-hot or all zero and never lasts more than one cycle.

## Configuration
- `PISO_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP;
  - `tx` = XOR of the 8 latched bits (even parity);
  - frame is 11 bit periods.
- Not defined:
  - PARITY state and its logic are absent;
  - DATA goes directly to STOP;
  - frame is 10 bit periods.

## Test plan
- Reset, CLKS_PER_BIT=4, `req[1]`=1 with byte 0xA5 → `ack[1]` pulses once, `grant_id`=1. `tx` sequence per 4-cycle period: 0,1,0,1,0,0,1,0,1,1 (parity 0 inserted before stop if enabled). `done` fires at cycle 40 (44 with parity).
- All four `req` held high continuously → grants 0,1,2,3,0 in order, with no idle cycle between frames and `busy` constantly high.
- `req[2]` and `req[3]` rise on the same edge right after requester 2 was last granted → requester 3 wins, then requester 2.
- `rst_n` pulsed low mid-DATA → `tx`=1 and `busy`=0 immediately, asynchronously with no clock edge. No `done`. The next request restarts with a full start bit.
- `data` changed while `busy` → transmitted bits match the value present at the grant edge.
- `PISO_PARITY_EN` with byte 0x07 → parity bit 1; with byte 0x03 → parity bit 0.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// -----------------------------------------------------------------------------
// piso_tx_scheduler
//
// Round-robin transmit scheduler that shares one serial output line among NREQ
// byte producers. The winning requester's byte is latched on the grant edge,
// then sent as a frame: one start bit (0), eight data bits MSB first, an
// optional even-parity bit, and one stop bit (1). Each bit lasts CLKS_PER_BIT
// clocks. A new grant can happen on the last stop-bit cycle, so frames can run
// back to back with no idle gap.
//
// Optional feature: define PISO_PARITY_EN to insert an even-parity bit
// (XOR of the 8 latched data bits) between the data bits and the stop bit.
// Without it the frame is 10 bit periods long.
//
// Parameters:
//   NREQ          number of requesters (2..8)
//   CLKS_PER_BIT  clock cycles per serial bit (>=2)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester transmit request (level, held until ack)
//   data      byte of requester k on bits [8k+7:8k], sampled on the grant edge
//   ack       one-cycle one-hot pulse: byte of requester k latched
//   grant_id  index of the requester owning the current frame
//   busy      high while a frame is on the line
//   done      one-cycle pulse in the last cycle of the stop bit
//   tx        serial line, idle high
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module piso_tx_scheduler #(
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       data,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    done,
    output logic                    tx
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shreg_reg, shreg_next;
    logic [IDW-1:0]  last_reg, last_next;
    logic [IDW-1:0]  grant_id_reg, grant_id_next;
    logic [NREQ-1:0] ack_reg, ack_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            tx_reg, tx_next;

    logic            cnt_last;
    logic            grant;
    logic [IDW-1:0]  win_idx;

    assign cnt_last = (cnt_reg == CNT_MAX);

    // A grant is only allowed when the line is free: in IDLE, or on the final
    // stop-bit cycle so the next frame starts on the very next clock.
    assign grant = (|req) &&
                   ((state_reg == IDLE) || ((state_reg == STOP) && cnt_last));

    // Round-robin winner: candidates are visited from farthest to nearest
    // (relative to last_reg), so the nearest requesting index after last_reg
    // is the final assignment and wins.
    always_comb begin
        win_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[IDW'((int'(last_reg) + i) % NREQ)]) begin
                win_idx = IDW'((int'(last_reg) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_last ? '0 : cnt_reg + CW'(1);
        bit_idx_next  = bit_idx_reg;
        shreg_next    = shreg_reg;
        last_next     = last_reg;
        grant_id_next = grant_id_reg;
        ack_next      = '0;
        tx_next       = 1'b1;
        busy_next     = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
            end
            START: begin
                if (cnt_last) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd7;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    if (bit_idx_reg == 3'd0) begin
`ifdef PISO_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg - 3'd1;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Grant overrides the STOP->IDLE return, giving back-to-back frames.
        if (grant) begin
            state_next    = START;
            cnt_next      = '0;
            shreg_next    = data[{win_idx, 3'b000} +: 8];
            last_next     = win_idx;
            grant_id_next = win_idx;
            ack_next      = NREQ'(1) << win_idx;
        end

        // Outputs are derived from the upcoming state so they can be
        // registered without adding a cycle of latency.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_reg[bit_idx_next];
`ifdef PISO_PARITY_EN
            PARITY:  tx_next = ^shreg_reg;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= 3'd7;
            shreg_reg    <= '0;
            last_reg     <= IDW'(NREQ - 1);
            grant_id_reg <= '0;
            ack_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shreg_reg    <= shreg_next;
            last_reg     <= last_next;
            grant_id_reg <= grant_id_next;
            ack_reg      <= ack_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            tx_reg       <= tx_next;
        end
    end

    assign ack      = ack_reg;
    assign grant_id = grant_id_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign tx       = tx_reg;

endmodule
